// File: rtl/counter_pkg.sv
// ============================================================================
// Module      : counter_pkg
// Description : Mode and direction constants shared by the counter blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;
    localparam logic CNT_DOWN = 1'b0;
    localparam logic CNT_UP   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/counter_mod_updown.sv
// ============================================================================
// Module      : counter_mod_updown
// Description : Modulo-N up/down counter with clear, load, wrap/saturate,
//               cascade carry and registered wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_mod_updown
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int SATURATE  = 0,
    parameter int RESET_VAL = 0
) (
    input  logic             C_CLOCK_50,
    input  logic             C_Reset,
    input  logic             C_Enable,
    input  logic             C_Up,
    input  logic             C_Clear,
    input  logic             C_Load,
    input  logic [WIDTH-1:0] C_LoadData,
    output logic [WIDTH-1:0] C_DataCounter_Out,
    output logic             C_Counter_Out,
    output logic             C_Carry_Out,
    output logic             C_Wrap_Pulse
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   c_MOD = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_RST = WIDTH'(RESET_VAL);
    localparam logic             c_SAT = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

    if (MODULUS < 2 || MODULUS > (1 << WIDTH) || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_params
        $error("counter_mod_updown: illegal MODULUS/RESET_VAL for WIDTH");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;
    logic             at_min;
    logic             out_of_range;
    logic             load_over;

    always_comb begin
        at_max       = (count_q == c_MAX);
        at_min       = (count_q == '0);
        out_of_range = ({1'b0, count_q} >= c_MOD);
        load_over    = ({1'b0, C_LoadData} >= c_MOD);
        count_d      = count_q;
        wrap_d       = 1'b0;

        if (C_Clear) begin
            count_d = '0;
        end else if (C_Load) begin
            count_d = load_over ? c_MAX : C_LoadData;
        end else if (out_of_range) begin
            // Unused codes recover to zero whether enabled or holding
            count_d = '0;
        end else if (C_Enable) begin
            if (C_Up == CNT_UP) begin
                if (!at_max) begin
                    count_d = count_q + 1'b1;
                end else if (c_SAT == CNT_WRAP) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    count_d = count_q - 1'b1;
                end else if (c_SAT == CNT_WRAP) begin
                    count_d = c_MAX;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge C_CLOCK_50 or posedge C_Reset) begin
        if (C_Reset) begin
            count_q <= c_RST;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Terminal count follows C_Up combinationally so a cascade sees it same-cycle
    assign C_DataCounter_Out = count_q;
    assign C_Counter_Out     = (C_Up == CNT_UP) ? at_max : at_min;
    assign C_Carry_Out       = C_Counter_Out & C_Enable;
    assign C_Wrap_Pulse      = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_mod_updown.sv
// ============================================================================
// Module      : tb_counter_mod_updown
// Description : Self-checking bench for counter_mod_updown (wrap, binary,
//               saturate and two-digit cascade instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_mod_updown;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       en_w = 1'b0, up_w = 1'b1, clr_w = 1'b0, ld_w = 1'b0;
    logic [3:0] ldd_w = 4'd0;
    logic       en_s = 1'b0, up_s = 1'b1, clr_s = 1'b0, ld_s = 1'b0;
    logic [3:0] ldd_s = 4'd0;
    logic       en_c = 1'b0;

    logic [3:0] cnt_w, cnt_b, cnt_s, cnt_l, cnt_h;
    logic       tc_w, tc_b, tc_s, tc_l, tc_h;
    logic       cy_w, cy_b, cy_s, cy_l, cy_h;
    logic       wp_w, wp_b, wp_s, wp_l, wp_h;

    int n_checks = 0;
    int n_fail   = 0;

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(3)) u_wrap (
        .C_CLOCK_50(clk), .C_Reset(rst), .C_Enable(en_w), .C_Up(up_w), .C_Clear(clr_w),
        .C_Load(ld_w), .C_LoadData(ldd_w), .C_DataCounter_Out(cnt_w), .C_Counter_Out(tc_w),
        .C_Carry_Out(cy_w), .C_Wrap_Pulse(wp_w));

    counter_mod_updown #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VAL(0)) u_bin (
        .C_CLOCK_50(clk), .C_Reset(rst), .C_Enable(en_w), .C_Up(up_w), .C_Clear(clr_w),
        .C_Load(ld_w), .C_LoadData(ldd_w), .C_DataCounter_Out(cnt_b), .C_Counter_Out(tc_b),
        .C_Carry_Out(cy_b), .C_Wrap_Pulse(wp_b));

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VAL(3)) u_sat (
        .C_CLOCK_50(clk), .C_Reset(rst), .C_Enable(en_s), .C_Up(up_s), .C_Clear(clr_s),
        .C_Load(ld_s), .C_LoadData(ldd_s), .C_DataCounter_Out(cnt_s), .C_Counter_Out(tc_s),
        .C_Carry_Out(cy_s), .C_Wrap_Pulse(wp_s));

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_lo (
        .C_CLOCK_50(clk), .C_Reset(rst), .C_Enable(en_c), .C_Up(1'b1), .C_Clear(1'b0),
        .C_Load(1'b0), .C_LoadData(4'd0), .C_DataCounter_Out(cnt_l), .C_Counter_Out(tc_l),
        .C_Carry_Out(cy_l), .C_Wrap_Pulse(wp_l));

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_hi (
        .C_CLOCK_50(clk), .C_Reset(rst), .C_Enable(cy_l), .C_Up(1'b1), .C_Clear(1'b0),
        .C_Load(1'b0), .C_LoadData(4'd0), .C_DataCounter_Out(cnt_h), .C_Counter_Out(tc_h),
        .C_Carry_Out(cy_h), .C_Wrap_Pulse(wp_h));

    // ---------------- behavioural model ----------------
    int m_cnt[5];
    bit m_wp[5];

    function automatic int nxt(int cur, int md, bit sat, bit en, bit up, bit clr, bit ld, int ldd);
        if (clr) return 0;
        if (ld) return (ldd >= md) ? md - 1 : ldd;
        if (cur >= md) return 0;
        if (!en) return cur;
        if (up) return (sat && cur == md - 1) ? cur : (cur + 1) % md;
        return (sat && cur == 0) ? cur : (cur + md - 1) % md;
    endfunction

    function automatic bit wrp(int cur, int md, bit sat, bit en, bit up, bit clr, bit ld);
        return !clr && !ld && en && !sat && cur < md && (up ? cur == md - 1 : cur == 0);
    endfunction

    function automatic bit mtc(int cur, int md, bit up);
        return up ? (cur == md - 1) : (cur == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt[0] <= 3; m_cnt[1] <= 0; m_cnt[2] <= 3; m_cnt[3] <= 0; m_cnt[4] <= 0;
            for (int i = 0; i < 5; i++) m_wp[i] <= 1'b0;
        end else begin
            m_cnt[0] <= nxt(m_cnt[0], 10, 0, en_w, up_w, clr_w, ld_w, int'(ldd_w));
            m_wp[0]  <= wrp(m_cnt[0], 10, 0, en_w, up_w, clr_w, ld_w);
            m_cnt[1] <= nxt(m_cnt[1], 16, 0, en_w, up_w, clr_w, ld_w, int'(ldd_w));
            m_wp[1]  <= wrp(m_cnt[1], 16, 0, en_w, up_w, clr_w, ld_w);
            m_cnt[2] <= nxt(m_cnt[2], 10, 1, en_s, up_s, clr_s, ld_s, int'(ldd_s));
            m_wp[2]  <= wrp(m_cnt[2], 10, 1, en_s, up_s, clr_s, ld_s);
            m_cnt[3] <= nxt(m_cnt[3], 10, 0, en_c, 1'b1, 1'b0, 1'b0, 0);
            m_wp[3]  <= wrp(m_cnt[3], 10, 0, en_c, 1'b1, 1'b0, 1'b0);
            m_cnt[4] <= nxt(m_cnt[4], 10, 0, mtc(m_cnt[3], 10, 1'b1) & en_c, 1'b1, 1'b0, 1'b0, 0);
            m_wp[4]  <= wrp(m_cnt[4], 10, 0, mtc(m_cnt[3], 10, 1'b1) & en_c, 1'b1, 1'b0, 1'b0);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string nm, input int idx, input int md, input logic [3:0] cnt,
                       input logic tc, input logic cy, input logic wp, input bit up, input bit en);
        bit etc;
        etc = mtc(m_cnt[idx], md, up);
        check({nm, ".count"}, 32'(cnt), 32'(m_cnt[idx]));
        check({nm, ".tc"},    32'(tc),  32'(etc));
        check({nm, ".carry"}, 32'(cy),  32'(etc & en));
        check({nm, ".wrap"},  32'(wp),  32'(m_wp[idx]));
    endtask

    always @(negedge clk) begin
        cmp("wrap", 0, 10, cnt_w, tc_w, cy_w, wp_w, up_w, en_w);
        cmp("bin",  1, 16, cnt_b, tc_b, cy_b, wp_b, up_w, en_w);
        cmp("sat",  2, 10, cnt_s, tc_s, cy_s, wp_s, up_s, en_s);
        cmp("lo",   3, 10, cnt_l, tc_l, cy_l, wp_l, 1'b1, en_c);
        cmp("hi",   4, 10, cnt_h, tc_h, cy_h, wp_h, 1'b1, mtc(m_cnt[3], 10, 1'b1) & en_c);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int seq2[12];
        seq2 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset and hold
        repeat (5) tick();
        check("t1.count", 32'(cnt_w), 32'd3);
        check("t1.wrap",  32'(wp_w),  32'd0);
        check("t1.tc",    32'(tc_w),  32'd0);
        check("t1.sat",   32'(cnt_s), 32'd3);

        // wrap up
        clr_w = 1'b1; tick(); clr_w = 1'b0;
        check("t2.clear", 32'(cnt_w), 32'd0);
        en_w = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t2.count", 32'(cnt_w), 32'(seq2[i]));
            check("t2.wrap",  32'(wp_w),  (i == 9) ? 32'd1 : 32'd0);
            if (seq2[i] == 9) begin
                check("t2.tc",    32'(tc_w), 32'd1);
                check("t2.carry", 32'(cy_w), 32'd1);
            end
        end

        // wrap down and direction flip
        up_w = 1'b0;
        tick(); check("t3.down1", 32'(cnt_w), 32'd1);
        tick(); check("t3.down0", 32'(cnt_w), 32'd0);
        tick(); en_w = 1'b0;
        check("t3.wrap9",  32'(cnt_w), 32'd9);
        check("t3.wpulse", 32'(wp_w),  32'd1);
        #1 check("t3.tc_dn", 32'(tc_w), 32'd0);
        up_w = 1'b1;
        #1 check("t3.tc_up", 32'(tc_w), 32'd1);
        check("t3.cy_off", 32'(cy_w), 32'd0);
        en_w = 1'b1;
        #1 check("t3.cy_on", 32'(cy_w), 32'd1);
        tick(); en_w = 1'b0;
        check("t3.to0",    32'(cnt_w), 32'd0);
        check("t3.wpulse2", 32'(wp_w), 32'd1);

        // saturate
        ld_s = 1'b1; ldd_s = 4'd8; tick(); ld_s = 1'b0;
        check("t4.load8", 32'(cnt_s), 32'd8);
        en_s = 1'b1; up_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4.count", 32'(cnt_s), 32'd9);
            check("t4.wrap",  32'(wp_s),  32'd0);
            check("t4.carry", 32'(cy_s),  32'd1);
        end
        up_s = 1'b0; ld_s = 1'b1; ldd_s = 4'd1;
        tick(); ld_s = 1'b0;
        check("t4.ldwins", 32'(cnt_s), 32'd1);
        tick(); tick();
        check("t4.hold0", 32'(cnt_s), 32'd0);
        check("t4.wrap0", 32'(wp_s),  32'd0);
        check("t4.cy0",   32'(cy_s),  32'd1);
        en_s = 1'b0;

        // priority and clamp
        clr_w = 1'b1; ld_w = 1'b1; ldd_w = 4'd5; en_w = 1'b1;
        tick(); clr_w = 1'b0;
        check("t5.clrwins", 32'(cnt_w), 32'd0);
        ldd_w = 4'd14; tick();
        check("t5.clamp",  32'(cnt_w), 32'd9);
        check("t5.bin14",  32'(cnt_b), 32'd14);
        ldd_w = 4'd4; tick();
        check("t5.ld_en",  32'(cnt_w), 32'd4);
        ldd_w = 4'd15; tick(); ld_w = 1'b0; up_w = 1'b1;
        check("t5.bin15",  32'(cnt_b), 32'd15);
        tick(); en_w = 1'b0;
        check("t5.w_wrap", 32'(cnt_w), 32'd0);
        check("t5.w_wp",   32'(wp_w),  32'd1);
        check("t5.b_wrap", 32'(cnt_b), 32'd0);
        check("t5.b_wp",   32'(wp_b),  32'd1);

        // cascade and async reset
        en_c = 1'b1;
        repeat (105) tick();
        check("t6.hi", 32'(cnt_h), 32'd0);
        check("t6.lo", 32'(cnt_l), 32'd5);
        repeat (5) tick();
        check("t6.hi1",  32'(cnt_h), 32'd1);
        check("t6.lo_wp", 32'(wp_l), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6.rst_hi", 32'(cnt_h), 32'd0);
        check("t6.rst_lo", 32'(cnt_l), 32'd0);
        check("t6.rst_wp", 32'(wp_l),  32'd0);
        check("t6.rst_w",  32'(cnt_w), 32'd3);
        en_c = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0; en_c = 1'b1;
        repeat (3) tick();
        check("t6.resume", 32'(cnt_l), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/counter_mod_updown.md
Name: counter_mod_updown

Overview:
Parametrised modulo-N up/down counter. It is the general-purpose timing and sequence counter for the game datapath, used for lane-movement ticks, animation frames and score digits. It adds synchronous clear, parallel load, direction control, a wrap/saturate mode, a cascade carry and a registered wrap pulse. Instances chain through C_Carry_Out into the next stage's C_Enable to build multi-digit counters.

Parameters:
WIDTH, 4, count register width in bits.
MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2^WIDTH; elaboration errors outside this range.
SATURATE, 0, 0 = wrap at the ends, 1 = hold at the ends.
RESET_VAL, 0, count value after reset. Must be less than MODULUS.

Ports:
C_CLOCK_50  in  1  system clock; all state updates on its rising edge
C_Reset  in  1  asynchronous, active-high reset
C_Enable  in  1  count enable; advances the count one step per cycle when high
C_Up  in  1  direction: 1 = increment, 0 = decrement
C_Clear  in  1  synchronous clear to 0
C_Load  in  1  synchronous parallel load
C_LoadData  in  WIDTH  value to load
C_DataCounter_Out  out  WIDTH  current count, driven directly from the register
C_Counter_Out  out  1  terminal count, combinational
C_Carry_Out  out  1  cascade carry, combinational: C_Counter_Out & C_Enable
C_Wrap_Pulse  out  1  registered one-cycle pulse after a wrap

Behaviour:
- Reset (asynchronous, active-high): count <= RESET_VAL and C_Wrap_Pulse <= 0, immediately and independent of the clock. After reset deasserts, the first update happens on the next rising edge.
- Update priority on each rising edge: C_Clear > C_Load > C_Enable > hold.
- Clear: count <= 0. No wrap pulse.
- Load: count <= C_LoadData. If C_LoadData >= MODULUS, count <= MODULUS-1 (clamped). No wrap pulse.
- Enable with C_Up=1:
  - count < MODULUS-1: count+1.
  - count = MODULUS-1: in wrap mode, count <= 0 and wrap event; in saturate mode, hold.
- Enable with C_Up=0:
  - count > 0: count-1.
  - count = 0: in wrap mode, count <= MODULUS-1 and wrap event; in saturate mode, hold.
- C_Wrap_Pulse: registered. It is 1 for exactly the cycle after a wrap event and 0 otherwise. It is never asserted in saturate mode.
- C_Counter_Out: combinational from the count and C_Up. It is 1 when (C_Up & count==MODULUS-1) | (~C_Up & count==0). It is not gated by enable, and a change on C_Up changes it within the same cycle.
- C_Carry_Out: combinational and asserted in the same cycle as the step that wraps, so a cascaded stage advances on the same edge. It is asserted in saturate mode too; saturating chains are the user's concern.
- Arithmetic is modulo MODULUS with no overflow into unused codes. Any count >= MODULUS, which is only reachable through a fault, steps to 0 on the next enabled or held edge.
- Latency: one cycle from C_Enable, C_Load or C_Clear to C_DataCounter_Out.
- C_Up is sampled on the same edge as C_Enable. A direction change takes effect on that step with no dead cycle.
- Reset asserted mid-operation overrides everything, including a pending wrap pulse, which is cleared.
- MODULUS = 2^WIDTH is a legal natural binary counter. The same compare logic applies.

Decomposition:
- Shared package counter_pkg: mode constants CNT_WRAP=0 and CNT_SAT=1, direction constants CNT_DOWN=0 and CNT_UP=1.
- A single module with no sub-module. Next-state logic is combinational, the state register is sequential and the output logic is combinational. Multi-digit counting is done by instantiating several copies, not inside this block.

Test Plan:
1. Reset and hold: WIDTH=4, MODULUS=10, RESET_VAL=3; pulse reset, then C_Enable=0 for 5 cycles -> count stays 3, C_Wrap_Pulse=0, C_Counter_Out=0 with C_Up=1.
2. Wrap up: C_Up=1, C_Enable=1 from 0 for 12 cycles -> counts 1..9,0,1,2. C_Counter_Out=1 while count=9. C_Carry_Out=1 in that cycle. C_Wrap_Pulse=1 only in the cycle where count=0 after the wrap.
3. Wrap down and direction flip: from 1 with C_Up=0 -> 0, then 9 with a wrap pulse. Set C_Up=1 while count=9 -> C_Counter_Out=1 in the same cycle, and the next step gives 0.
4. Saturate: SATURATE=1, C_Up=1 from 8 for 4 cycles -> 9,9,9,9. C_Wrap_Pulse never asserted, C_Carry_Out=1 while enabled at 9.
5. Priority and clamp: C_Clear=1, C_Load=1, C_LoadData=5 in the same cycle -> 0. Next cycle C_Load=1, C_LoadData=14 -> 9. C_Load=1 together with C_Enable=1 -> the load value wins.
6. Cascade and async reset: two instances with MODULUS=10, carry chained, 105 enables -> high digit 0 and low digit 5 after wrap, i.e. 05 reached via 99->00. Assert C_Reset mid-clock during a wrap cycle -> both counts go to RESET_VAL immediately and C_Wrap_Pulse=0.
